sipo_frame_ctrl: RTL
====================

Name: sipo_frame_ctrl

Overview:
Frame controller that sequences a serial-in/parallel-out shift register. It accepts a gated serial bit stream framed by a START pulse and counts WIDTH bits into the shift core. It then transfers the completed word into an output holding register and presents it downstream with a valid/ready handshake. It sits between a serial input source and parallel-word consumers, and flags words lost to downstream backpressure.

Parameters:
WIDTH, 4, bits per frame / parallel word width (>=2)
MSB_FIRST, 1, 1: first received bit lands in PO_DATA[WIDTH-1]; 0: first bit lands in PO_DATA[0]

Ports:
CLK  input  1  system clock, all logic on rising edge
CLR  input  1  synchronous active-high reset
START  input  1  single-cycle frame start request
ABORT  input  1  cancel current frame
SI  input  1  serial data bit
SI_EN  input  1  SI is valid this cycle (bit strobe)
PO_DATA  output  WIDTH  completed parallel word (holding register)
PO_VALID  output  1  PO_DATA holds an unconsumed word
PO_READY  input  1  downstream accepts word
BUSY  output  1  frame in progress (state SHIFT)
BIT_CNT  output  CNTW  bits received in current frame; CNTW = max(1, clog2(WIDTH))
OVERRUN  output  1  sticky: a completed word was dropped
CLR_OVR  input  1  clears OVERRUN

Behaviour:
- Interface: one clock CLK; CLR is synchronous and active-high. No asynchronous logic.
- Reset (CLR=1 at an edge): state IDLE, shift register 0, BIT_CNT 0, PO_DATA 0, PO_VALID 0, BUSY 0, OVERRUN 0. CLR overrides every other input, including mid-frame and mid-handshake.
- State IDLE:
  - START=1 and ABORT=0 -> SHIFT.
  - Shift register and BIT_CNT are cleared to 0 on that edge.
  - SI/SI_EN are ignored in IDLE, including in the START cycle.
- State SHIFT, BUSY=1:
  - Each edge with SI_EN=1 shifts SI in. MSB_FIRST=1: sr <= {sr[WIDTH-2:0], SI}. MSB_FIRST=0: sr <= {SI, sr[WIDTH-1:1]}.
  - BIT_CNT increments on each such edge.
  - SI_EN=0: register and count hold, so gaps are allowed.
  - START in SHIFT is ignored.
- Word completion: an edge in SHIFT with SI_EN=1 and BIT_CNT==WIDTH-1.
  - The next-shifted value loads into PO_DATA, so PO_VALID is 1 the cycle after the last bit's edge (latency 1 from last bit).
  - State returns to IDLE and BIT_CNT becomes 0.
  - A new START is accepted in the following cycle.
- Output handshake:
  - A word transfers on an edge with PO_VALID=1 and PO_READY=1.
  - PO_DATA is stable while PO_VALID=1 and PO_READY=0.
  - After a transfer with no new word, PO_VALID drops to 0 and PO_DATA holds its last value.
- Completion while PO_VALID=1:
  - If PO_READY=1 that cycle: the new word loads and PO_VALID stays 1. This is not an overrun.
  - If PO_READY=0: the new word is dropped, PO_DATA is unchanged and OVERRUN is set to 1.
- OVERRUN: sticky until CLR or CLR_OVR. If CLR_OVR and a new overrun occur on the same edge, set wins.
- ABORT=1:
  - In SHIFT: go to IDLE, BIT_CNT 0, no word produced. PO_DATA, PO_VALID and OVERRUN are untouched.
  - ABORT beats START on the same edge.
  - ABORT on the completion edge beats completion, and the word is discarded.
- PO_READY with PO_VALID=0 has no effect.

Decomposition:
- Shared header package sipo_ctrl_pkg holds:
  - State encodings: ST_IDLE=1'b0, ST_SHIFT=1'b1.
  - The CNTW width helper function/macro.
- One sub-module, sipo_shift_core, parameterised by WIDTH and MSB_FIRST.
  - Ports: CLK, CLR, LOAD_ZERO, SHIFT_EN, SI, SR.
  - It holds only the shift register.
- The FSM, counter, holding register, handshake and overrun logic live in sipo_frame_ctrl.

Test Plan:
Defaults WIDTH=4, MSB_FIRST=1 unless stated.
1. CLR=1 for 2 edges, then START; SI 1,1,0,1 with SI_EN=1 on 4 consecutive edges; PO_READY=1 -> one cycle after the 4th bit, PO_DATA=4'b1101 and PO_VALID=1 for 1 cycle; BUSY is 1 for exactly 4 cycles; BIT_CNT steps 0,1,2,3,0.
2. MSB_FIRST=0, same bits 1,1,0,1 -> PO_DATA=4'b1011.
3. Bits 1,0,1,0 with SI_EN deasserted for 3 cycles between bits 2 and 3 -> BIT_CNT holds at 2 during the gap; final PO_DATA=4'b1010.
4. Backpressure, PO_READY=0:
   - Frames 1,0,0,1 then 0,1,1,0 -> PO_DATA stays 4'b1001, OVERRUN=1.
   - Then PO_READY=1 -> one transfer, PO_VALID=0.
   - Then CLR_OVR -> OVERRUN=0.
5. Completion coincident with transfer: first word 4'b0011 pending; second frame's last bit lands on the edge where PO_READY=1 -> PO_DATA=4'b1100, PO_VALID stays 1, OVERRUN=0.
6. START, 2 bits, then ABORT -> IDLE, BIT_CNT=0, no PO_VALID. Then START and bits 0,1,1,0 -> PO_DATA=4'b0110. Repeat with CLR asserted mid-frame -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/sipo_ctrl_pkg.sv
// Shared definitions for the SIPO frame controller: FSM state encoding and
// the bit-counter width helper.
package sipo_ctrl_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Counter width for a frame of `width` bits, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned width);
    int unsigned w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sipo_frame_ctrl_if.sv
// Serial-in / parallel-out frame bus. The master side drives the serial stream,
// frame control and the downstream ready; the slave side is the controller.
interface sipo_frame_ctrl_if #(
  parameter int unsigned WIDTH = 4
) ();
  import sipo_ctrl_pkg::*;

  localparam int unsigned CNTW = cnt_w(WIDTH);

  logic             START;
  logic             ABORT;
  logic             SI;
  logic             SI_EN;
  logic [WIDTH-1:0] PO_DATA;
  logic             PO_VALID;
  logic             PO_READY;
  logic             BUSY;
  logic [CNTW-1:0]  BIT_CNT;
  logic             OVERRUN;
  logic             CLR_OVR;

  modport master (
    output START, ABORT, SI, SI_EN, PO_READY, CLR_OVR,
    input  PO_DATA, PO_VALID, BUSY, BIT_CNT, OVERRUN
  );

  modport slave (
    input  START, ABORT, SI, SI_EN, PO_READY, CLR_OVR,
    output PO_DATA, PO_VALID, BUSY, BIT_CNT, OVERRUN
  );

endinterface

// File: rtl/sipo_shift_core.sv
// Bare shift register: cleared at frame start, shifts one bit per strobe.
module sipo_shift_core #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             LOAD_ZERO,
  input  logic             SHIFT_EN,
  input  logic             SI,
  output logic [WIDTH-1:0] SR
);

  logic [WIDTH-1:0] sr_q;

  // Clear has priority over shift; MSB_FIRST picks the shift direction.
  always_ff @(posedge CLK) begin
    if (CLR || LOAD_ZERO) begin
      sr_q <= '0;
    end else if (SHIFT_EN) begin
      if (MSB_FIRST) begin
        sr_q <= {sr_q[WIDTH-2:0], SI};
      end else begin
        sr_q <= {SI, sr_q[WIDTH-1:1]};
      end
    end
  end

  assign SR = sr_q;

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Frame controller: counts WIDTH strobed bits into the shift core, moves the
// finished word into a holding register and hands it downstream with
// valid/ready, flagging words dropped under backpressure.
module sipo_frame_ctrl
  import sipo_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input logic                CLK,
  input logic                CLR,
  sipo_frame_ctrl_if.slave   bus
);

  localparam int unsigned CNTW = cnt_w(WIDTH);

  state_e           state_q;
  logic [CNTW-1:0]  cnt_q;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic [WIDTH-1:0] po_data_q;
  logic             po_valid_q;
  logic             ovr_q;

  logic start_ok, shift_en, last_bit, complete, accept, drop;

  // Frame control decode; ABORT masks both frame start and shifting.
  always_comb begin
    start_ok = (state_q == ST_IDLE) && bus.START && !bus.ABORT;
    shift_en = (state_q == ST_SHIFT) && bus.SI_EN && !bus.ABORT;
    last_bit = (cnt_q == CNTW'(WIDTH - 1));
    complete = shift_en && last_bit;
    // A pending word consumed on this same edge makes room for the new one.
    accept   = complete && (!po_valid_q || bus.PO_READY);
    drop     = complete && po_valid_q && !bus.PO_READY;
  end

  // Value the shift core will hold after this edge, captured on completion.
  always_comb begin
    if (MSB_FIRST) begin
      sr_next = {sr[WIDTH-2:0], bus.SI};
    end else begin
      sr_next = {bus.SI, sr[WIDTH-1:1]};
    end
  end

  sipo_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .CLK       (CLK),
    .CLR       (CLR),
    .LOAD_ZERO (start_ok),
    .SHIFT_EN  (shift_en),
    .SI        (bus.SI),
    .SR        (sr)
  );

  // Frame FSM and bit counter.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            state_q <= ST_SHIFT;
            cnt_q   <= '0;
          end
        end
        ST_SHIFT: begin
          if (bus.ABORT) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (bus.SI_EN) begin
            if (last_bit) begin
              state_q <= ST_IDLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNTW'(1);
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Output holding register, valid/ready handshake and sticky overrun.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      po_data_q  <= '0;
      po_valid_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      if (accept) begin
        po_data_q  <= sr_next;
        po_valid_q <= 1'b1;
      end else if (po_valid_q && bus.PO_READY) begin
        po_valid_q <= 1'b0;
      end
      // A new overrun wins over a same-edge clear.
      if (drop) begin
        ovr_q <= 1'b1;
      end else if (bus.CLR_OVR) begin
        ovr_q <= 1'b0;
      end
    end
  end

  assign bus.PO_DATA  = po_data_q;
  assign bus.PO_VALID = po_valid_q;
  assign bus.BUSY     = (state_q == ST_SHIFT);
  assign bus.BIT_CNT  = cnt_q;
  assign bus.OVERRUN  = ovr_q;

endmodule
